// File: rtl/reg_file.sv
// Multi-entry register bank: one enabled write port, two independent registered read ports.
// Define REGFILE_BYPASS_EN for write-first same-address collisions; the default build is read-first.
module reg_file #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_a_d;
    logic             rvalid_b_q, rvalid_b_d;
    logic [WIDTH-1:0] read_a, read_b;

    // A same-address collision returns either the incoming write data or the stored entry.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        read_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
        read_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];
`else
        read_a = mem_q[raddr_a];
        read_b = mem_q[raddr_b];
`endif
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        mem_d      = mem_q;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rvalid_a_d = re_a;
        rvalid_b_d = re_b;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        if (re_a) begin
            rdata_a_d = read_a;
        end
        if (re_b) begin
            rdata_b_d = read_b;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the array is reset as well, so unwritten entries read back as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             we = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic             re_a = 1'b0;
    logic [AW-1:0]    raddr_a = '0;
    logic [WIDTH-1:0] rdata_a;
    logic             rvalid_a;
    logic             re_b = 1'b0;
    logic [AW-1:0]    raddr_b = '0;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain array plus the expected output values.
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] exp_rdata_a = '0;
    logic [WIDTH-1:0] exp_rdata_b = '0;
    logic             exp_rvalid_a = 1'b0;
    logic             exp_rvalid_b = 1'b0;

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        v = model_mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ra) v = wdata;
`endif
        return v;
    endfunction

    // One rising edge: update the model from the inputs applied, then settle past the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            exp_rdata_a  = '0;
            exp_rdata_b  = '0;
            exp_rvalid_a = 1'b0;
            exp_rvalid_b = 1'b0;
        end else begin
            if (re_a) exp_rdata_a = model_read(raddr_a);
            if (re_b) exp_rdata_b = model_read(raddr_b);
            exp_rvalid_a = re_a;
            exp_rvalid_b = re_b;
            if (we) model_mem[waddr] = wdata;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; re_a = 1'b1; re_b = 1'b1;
        tick(); tick();
        n_checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got a=%b b=%b, want 0 0", rvalid_a, rvalid_b);
        end
        n_checks++;
        if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h, want 00 00", rdata_a, rdata_b);
        end
        idle(); re_a = 1'b1; raddr_a = 3'd3;
        tick();
        n_checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_then_read: got v=%b d=%h, want 1 00", rvalid_a, rdata_a);
        end
        idle();
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 3'd2; wdata = 8'hA5;
        tick();
        n_checks++;
        if (rvalid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_valid: got %b, want 0", rvalid_a);
        end
        idle(); re_a = 1'b1; raddr_a = 3'd2;
        tick();
        n_checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_read: got v=%b d=%h, want 1 a5", rvalid_a, rdata_a);
        end
        idle();
        tick();
        n_checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_hold: got v=%b d=%h, want 0 a5", rvalid_a, rdata_a);
        end
    endtask

    task automatic test_hold();
        idle(); waddr = 3'd2; wdata = 8'hFF;
        tick();
        re_a = 1'b1; raddr_a = 3'd2;
        tick();
        n_checks++;
        if (rdata_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL hold_we0: got %h, want a5", rdata_a);
        end
        idle();
    endtask

    task automatic test_dual_port();
        we = 1'b1; waddr = 3'd1; wdata = 8'h3C; tick();
        waddr = 3'd6; wdata = 8'h11; tick();
        idle(); re_a = 1'b1; raddr_a = 3'd1; re_b = 1'b1; raddr_b = 3'd6;
        tick();
        n_checks++;
        if (rdata_a !== 8'h3C || rdata_b !== 8'h11 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_port: got a=%h/%b b=%h/%b, want 3c/1 11/1",
                     rdata_a, rvalid_a, rdata_b, rvalid_b);
        end
        raddr_b = 3'd1;
        tick();
        n_checks++;
        if (rdata_a !== 8'h3C || rdata_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL same_addr_both: got a=%h b=%h, want 3c 3c", rdata_a, rdata_b);
        end
        idle();
    endtask

    task automatic test_collision();
        logic [WIDTH-1:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 8'h77;
`else
        want = 8'h22;
`endif
        we = 1'b1; waddr = 3'd4; wdata = 8'h22; tick();
        wdata = 8'h77; re_a = 1'b1; raddr_a = 3'd4; re_b = 1'b1; raddr_b = 3'd1;
        tick();
        n_checks++;
        if (rdata_a !== want || rdata_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL collision: got a=%h b=%h, want %h 3c", rdata_a, rdata_b, want);
        end
        we = 1'b0; re_b = 1'b0;
        tick();
        n_checks++;
        if (rdata_a !== 8'h77) begin
            n_fail++;
            $display("FAIL collision_after: got %h, want 77", rdata_a);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        re_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            raddr_a = (k[0]) ? 3'd6 : 3'd4;
            tick();
            n_checks++;
            if (rvalid_a !== 1'b1 || rdata_a !== ((k[0]) ? 8'h11 : 8'h77)) begin
                n_fail++;
                $display("FAIL back_to_back beat %0d: got v=%b d=%h", k, rvalid_a, rdata_a);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; we = 1'b1; waddr = 3'd0; wdata = 8'h55; re_b = 1'b1; raddr_b = 3'd0;
        tick();
        n_checks++;
        if (rvalid_b !== 1'b0 || rdata_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b d=%h, want 0 00", rvalid_b, rdata_b);
        end
        idle(); re_b = 1'b1; raddr_b = 3'd0;
        tick();
        n_checks++;
        if (rvalid_b !== 1'b1 || rdata_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_read: got v=%b d=%h, want 1 00", rvalid_b, rdata_b);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(31, 0) == 0);
            we      = 1'($urandom_range(1, 0));
            waddr   = 3'($urandom_range(7, 0));
            wdata   = 8'($urandom_range(255, 0));
            re_a    = 1'($urandom_range(1, 0));
            raddr_a = 3'($urandom_range(7, 0));
            re_b    = 1'($urandom_range(1, 0));
            raddr_b = ($urandom_range(3, 0) == 0) ? waddr : 3'($urandom_range(7, 0));
            if ($urandom_range(3, 0) == 0) raddr_a = waddr;
            tick();
            n_checks++;
            if (rdata_a !== exp_rdata_a || rvalid_a !== exp_rvalid_a ||
                rdata_b !== exp_rdata_b || rvalid_b !== exp_rvalid_b) begin
                n_fail++;
                $display("FAIL random cycle %0d: got a=%h/%b b=%h/%b, want a=%h/%b b=%h/%b", n,
                         rdata_a, rvalid_a, rdata_b, rvalid_b,
                         exp_rdata_a, exp_rvalid_a, exp_rdata_b, exp_rvalid_b);
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        test_reset();
        test_write_read();
        test_hold();
        test_dual_port();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Multi-entry register bank for the processor datapath: one write port with enable and two independent registered read ports. It generalises the single CE-gated 8-bit register into an addressable store. Writes capture on the rising clock edge when enabled, and reads return data one cycle after the request with a valid strobe. It sits between the ALU/bus writeback path and the operand-fetch logic.

## Interface
- WIDTH, 8, data width of every entry
- DEPTH, 8, number of entries; must be a power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable; sampled on rising edge of clk
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- re_a  in  1  read request, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WIDTH  read data, port A (registered)
- rvalid_a  out  1  one-cycle strobe: rdata_a updated this cycle
- re_b  in  1  read request, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WIDTH  read data, port B (registered)
- rvalid_b  out  1  one-cycle strobe: rdata_b updated this cycle

## Operation
- Reset: on a rising edge with rst=1, every entry is set to 0, rdata_a/rdata_b are set to 0, and rvalid_a/rvalid_b are set to 0.
- Reset priority: rst overrides we, re_a and re_b in the same cycle. No write or read takes effect.
- Write: on a rising edge with rst=0 and we=1, mem[waddr] ← wdata. With we=0, all entries hold.
- Read: on a rising edge with re_x=1, rdata_x ← mem[raddr_x] and rvalid_x ← 1.
- Read with re_x=0: rvalid_x ← 0, and rdata_x holds its last value. rdata is never cleared except by rst.
- Ports A and B are fully independent. A and B may use the same address in the same cycle; both return identical data.
- Read-during-write to the same address follows the Configuration rule below. A read to a different address is unaffected by the write.
- No internal state beyond the memory array and the output registers. There is no FSM and no backpressure: every request is served.
- Addresses are always in range, because DEPTH is a power of two and ADDR_W = log2(DEPTH).

## Timing
- Write latency: data written at edge N is visible to a read requested at edge N+1. That read appears on rdata at edge N+1, i.e. one cycle after the write edge.
- Read latency: request sampled at edge N; rdata_x and rvalid_x are valid from edge N, after clock-to-out, until edge N+1.
- Back-to-back reads: re_x held high for k cycles produces k consecutive valid beats, one per edge, at the addresses presented each cycle.
- After rst deasserts: the first edge with rst=0 may write or read. A read on that edge returns 0 for any unwritten address.
- Inputs must be stable setup-before the rising edge. Input changes between edges have no effect.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): we=1, re_x=1 and raddr_x==waddr on the same edge → rdata_x ← wdata, the new value.
- Undefined (read-first): in the same case, rdata_x ← the old mem[raddr_x]. The new value is readable from the next edge.
- The macro changes only the same-address collision case. Every other behaviour is identical in both builds.

## Test plan
- Reset then read: assert rst for 2 edges, release, then re_a=1, raddr_a=3 → rvalid_a=1 and rdata_a=0x00 after the next edge. Before that, both rvalid outputs are 0.
- Write/read: write 0xA5 to addr 2. Next cycle re_a=1, raddr_a=2 → rdata_a=0xA5, rvalid_a=1. The cycle after, with re_a=0 → rvalid_a=0 and rdata_a holds 0xA5.
- Hold on we=0: addr 2 contains 0xA5. Drive we=0, wdata=0xFF, waddr=2 for one edge, then read addr 2 → 0xA5.
- Dual-port: write 0x3C to addr 1 and 0x11 to addr 6. Then in the same cycle re_a (addr 1) and re_b (addr 6) → rdata_a=0x3C and rdata_b=0x11 on the same edge. Both valids are 1.
- Collision: addr 4 contains 0x22. On one edge, we=1, waddr=4, wdata=0x77 with re_a=1, raddr_a=4 → rdata_a=0x77 if REGFILE_BYPASS_EN is defined, else 0x22. A read on the following edge returns 0x77 in both builds.
- Reset mid-operation: with rst=1, we=1 (addr 0, 0x55) and re_b=1 (addr 0) on the same edge → no write happens and rvalid_b=0. A subsequent read of addr 0 returns 0x00.
